// File: rtl/sdram_protocol_monitor.sv
// SDRAM command-bus protocol monitor.
// Follows the power-up sequence, per-bank row state and timing, CAS latency
// on reads, and keeps sticky error flags plus a one-cycle error pulse.
// Optional build macro: SDRAM_MON_REFRESH_EN adds the refresh-interval check
// (err_sticky[8]). When the macro is undefined, that bit is tied to 0.
module sdram_protocol_monitor #(
   parameter int BANKS         = 4,
   parameter int BA_W          = 2,
   parameter int ADDR_W        = 13,
   parameter int INIT_CYCLES   = 10000,
   parameter int NUM_INIT_AREF = 2,
   parameter int T_RP          = 3,
   parameter int T_RCD         = 3,
   parameter int T_RFC         = 7,
   parameter int T_MRD         = 2,
   parameter int T_REFI        = 780,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sdr_cs_n,
   input  logic              sdr_ras_n,
   input  logic              sdr_cas_n,
   input  logic              sdr_we_n,
   input  logic [BA_W-1:0]   sdr_ba,
   input  logic [ADDR_W-1:0] sdr_addr,
   input  logic              sdr_rd_first,
   output logic              init_done,
   output logic [1:0]        cas_lat,
   output logic [8:0]        err_sticky,
   output logic              err_pulse,
   output logic [CNT_W-1:0]  aref_cnt,
   output logic [CNT_W-1:0]  act_cnt
);

   localparam int T_MAX_A = (T_RP > T_RCD) ? T_RP : T_RCD;
   localparam int T_MAX_B = (T_RFC > T_MRD) ? T_RFC : T_MRD;
   localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   // Timers hold T-1 at most.
   localparam int TW      = (T_MAX < 2) ? 1 : $clog2(T_MAX);
   localparam int PWR_W   = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
   localparam int AI_W    = (NUM_INIT_AREF < 2) ? 1 : $clog2(NUM_INIT_AREF);

   localparam logic [TW-1:0] TRP_LD  = TW'(T_RP - 1);
   localparam logic [TW-1:0] TRCD_LD = TW'(T_RCD - 1);
   localparam logic [TW-1:0] TRFC_LD = TW'(T_RFC - 1);
   localparam logic [TW-1:0] TMRD_LD = TW'(T_MRD - 1);

   typedef enum logic [2:0] {
      WAIT_PWR  = 3'd0,
      WAIT_PRE  = 3'd1,
      WAIT_AREF = 3'd2,
      WAIT_MRS  = 3'd3,
      RUN       = 3'd4
   } state_t;

   state_t                 state_r;
   logic [PWR_W-1:0]       pwr_cnt_r;
   logic [AI_W-1:0]        init_aref_r;
   logic [TW-1:0]          trp_r  [BANKS];
   logic [TW-1:0]          trcd_r [BANKS];
   logic [TW-1:0]          trfc_r;
   logic [TW-1:0]          tmrd_r;
   logic [BANKS-1:0]       open_r;
   logic [2:0]             exp_r;

   logic       is_nop_s, is_act_s, is_rd_s, is_wr_s, is_pre_s, is_aref_s, is_mrs_s;
   logic       is_rdwr_s, any_trp_s, any_open_s, run_s, init_bad_s, mode_bad_s;
   logic       refi_hit_s;
   logic [2:0] exp_nxt_s;
   logic [8:0] err_now_s;
   logic       unused_addr_s;

   // Saturating decrement for the timing counters.
   function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
      return (v == {TW{1'b0}}) ? v : v - TW'(1);
   endfunction

   // Saturating increment for the statistics counters.
   function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Command decode; DESEL behaves exactly like NOP.
   always_comb begin
      is_nop_s  = 1'b0;
      is_act_s  = 1'b0;
      is_rd_s   = 1'b0;
      is_wr_s   = 1'b0;
      is_pre_s  = 1'b0;
      is_aref_s = 1'b0;
      is_mrs_s  = 1'b0;
      case ({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n})
         4'b0111: is_nop_s  = 1'b1;
         4'b0011: is_act_s  = 1'b1;
         4'b0101: is_rd_s   = 1'b1;
         4'b0100: is_wr_s   = 1'b1;
         4'b0010: is_pre_s  = 1'b1;
         4'b0001: is_aref_s = 1'b1;
         4'b0000: is_mrs_s  = 1'b1;
         4'b0110: is_nop_s  = 1'b0;   // BST: a real command, no tracked effect
         default: is_nop_s  = 1'b1;   // cs_n high: DESEL
      endcase
   end

   // Bank summaries, init legality, mode decode and the next CAS expectation.
   always_comb begin
      is_rdwr_s  = is_rd_s | is_wr_s;
      run_s      = (state_r == RUN);
      any_open_s = |open_r;
      any_trp_s  = 1'b0;
      for (int b = 0; b < BANKS; b++) begin
         any_trp_s = any_trp_s | (trp_r[b] != {TW{1'b0}});
      end
      case (state_r)
         WAIT_PWR:  init_bad_s = ~is_nop_s;
         WAIT_PRE:  init_bad_s = ~is_nop_s & ~(is_pre_s & sdr_addr[10]);
         WAIT_AREF: init_bad_s = ~is_nop_s & ~is_aref_s;
         WAIT_MRS:  init_bad_s = ~is_nop_s & ~is_mrs_s;
         RUN:       init_bad_s = 1'b0;
         default:   init_bad_s = 1'b0;
      endcase
      mode_bad_s = ~((sdr_addr[6:4] == 3'b010) | (sdr_addr[6:4] == 3'b011))
                 | ((sdr_addr[2:0] == 3'b111) & sdr_addr[3]);
      // A read at this edge must show its first beat cas_lat edges later.
      exp_nxt_s  = {1'b0, exp_r[2:1]}
                 | {is_rd_s & (cas_lat == 2'd3), is_rd_s & (cas_lat == 2'd2), 1'b0};
      unused_addr_s = ^sdr_addr;
   end

`ifdef SDRAM_MON_REFRESH_EN
   localparam int REFI_W = $clog2(T_REFI + 1);
   logic [REFI_W-1:0] refi_cnt_r;

   // Fires once when the refresh interval elapses without an AREF.
   always_comb begin
      refi_hit_s = run_s & ~is_aref_s & (refi_cnt_r == REFI_W'(T_REFI - 1));
   end

   // Refresh-interval counter: restarts on AREF, holds once expired.
   always_ff @(posedge clk) begin
      if (rst) begin
         refi_cnt_r <= {REFI_W{1'b0}};
      end else if (!run_s || is_aref_s) begin
         refi_cnt_r <= {REFI_W{1'b0}};
      end else if (refi_cnt_r != REFI_W'(T_REFI)) begin
         refi_cnt_r <= refi_cnt_r + REFI_W'(1);
      end
   end
`else
   logic unused_refi_s;

   // Refresh-interval check not built.
   always_comb begin
      refi_hit_s    = 1'b0;
      unused_refi_s = (T_REFI > 0);
   end
`endif

   // Errors detected on the command sampled at this edge.
   always_comb begin
      err_now_s[0] = init_bad_s;
      err_now_s[1] = (is_act_s & (trp_r[sdr_ba] != {TW{1'b0}})) | (is_aref_s & any_trp_s);
      err_now_s[2] = is_rdwr_s & (trcd_r[sdr_ba] != {TW{1'b0}});
      err_now_s[3] = ~is_nop_s & (trfc_r != {TW{1'b0}});
      err_now_s[4] = ~is_nop_s & (tmrd_r != {TW{1'b0}});
      err_now_s[5] = run_s & ((is_act_s & open_r[sdr_ba])
                            | (is_rdwr_s & ~open_r[sdr_ba])
                            | ((is_aref_s | is_mrs_s) & any_open_s));
      err_now_s[6] = is_mrs_s & mode_bad_s;
      err_now_s[7] = exp_r[0] ^ sdr_rd_first;
      err_now_s[8] = refi_hit_s;
   end

   // Init sequence FSM and the init_done flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= WAIT_PWR;
         pwr_cnt_r   <= {PWR_W{1'b0}};
         init_aref_r <= {AI_W{1'b0}};
         init_done   <= 1'b0;
      end else begin
         case (state_r)
            WAIT_PWR: begin
               if (is_nop_s) begin
                  if (pwr_cnt_r == PWR_W'(INIT_CYCLES - 1)) state_r <= WAIT_PRE;
                  else pwr_cnt_r <= pwr_cnt_r + PWR_W'(1);
               end
            end
            WAIT_PRE: begin
               if (is_pre_s && sdr_addr[10]) state_r <= WAIT_AREF;
            end
            WAIT_AREF: begin
               if (is_aref_s) begin
                  if (init_aref_r == AI_W'(NUM_INIT_AREF - 1)) state_r <= WAIT_MRS;
                  else init_aref_r <= init_aref_r + AI_W'(1);
               end
            end
            WAIT_MRS: begin
               if (is_mrs_s) begin
                  state_r   <= RUN;
                  init_done <= 1'b1;
               end
            end
            RUN:     init_done <= 1'b1;
            default: state_r   <= WAIT_PWR;
         endcase
      end
   end

   // Per-bank row state and tRP/tRCD timers, global tRFC/tMRD timers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < BANKS; b++) begin
            trp_r[b]  <= {TW{1'b0}};
            trcd_r[b] <= {TW{1'b0}};
         end
         open_r <= {BANKS{1'b0}};
         trfc_r <= {TW{1'b0}};
         tmrd_r <= {TW{1'b0}};
      end else begin
         for (int b = 0; b < BANKS; b++) begin
            trp_r[b]  <= dec_sat(trp_r[b]);
            trcd_r[b] <= dec_sat(trcd_r[b]);
            if ((is_pre_s && (sdr_addr[10] || sdr_ba == BA_W'(b))) ||
                (is_rdwr_s && sdr_addr[10] && sdr_ba == BA_W'(b))) begin
               trp_r[b]  <= TRP_LD;
               open_r[b] <= 1'b0;
            end
            if (is_act_s && sdr_ba == BA_W'(b)) begin
               trcd_r[b] <= TRCD_LD;
               open_r[b] <= 1'b1;
            end
         end
         trfc_r <= is_aref_s ? TRFC_LD : dec_sat(trfc_r);
         tmrd_r <= is_mrs_s  ? TMRD_LD : dec_sat(tmrd_r);
      end
   end

   // Mode register shadow and read-beat expectation pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         cas_lat <= 2'd3;
         exp_r   <= 3'b000;
      end else begin
         if (is_mrs_s && !mode_bad_s) cas_lat <= sdr_addr[5:4];
         exp_r <= exp_nxt_s;
      end
   end

   // Sticky flags, new-error pulse and saturating statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_sticky <= 9'h000;
         err_pulse  <= 1'b0;
         aref_cnt   <= {CNT_W{1'b0}};
         act_cnt    <= {CNT_W{1'b0}};
      end else begin
         err_sticky <= err_sticky | err_now_s;
         err_pulse  <= |(err_now_s & ~err_sticky);
         if (is_aref_s) aref_cnt <= inc_sat(aref_cnt);
         if (is_act_s)  act_cnt  <= inc_sat(act_cnt);
      end
   end

endmodule

// File: tb/tb_sdram_protocol_monitor.sv
// Directed bench for sdram_protocol_monitor with default parameters.
module tb_sdram_protocol_monitor;

   localparam logic [3:0] C_NOP  = 4'b0111;
   localparam logic [3:0] C_ACT  = 4'b0011;
   localparam logic [3:0] C_RD   = 4'b0101;
   localparam logic [3:0] C_PRE  = 4'b0010;
   localparam logic [3:0] C_AREF = 4'b0001;
   localparam logic [3:0] C_MRS  = 4'b0000;
`ifdef SDRAM_MON_REFRESH_EN
   localparam logic [8:0] REFI_BIT = 9'h100;
`else
   localparam logic [8:0] REFI_BIT = 9'h000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
   logic [1:0]  ba = 2'd0;
   logic [12:0] addr = 13'h0000;
   logic        rd_first = 1'b0;
   logic        init_done;
   logic [1:0]  cas_lat;
   logic [8:0]  err_sticky;
   logic        err_pulse;
   logic [15:0] aref_cnt;
   logic [15:0] act_cnt;

   int total = 0;
   int bad   = 0;

   sdram_protocol_monitor dut (
      .clk(clk), .rst(rst),
      .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
      .sdr_ba(ba), .sdr_addr(addr), .sdr_rd_first(rd_first),
      .init_done(init_done), .cas_lat(cas_lat), .err_sticky(err_sticky),
      .err_pulse(err_pulse), .aref_cnt(aref_cnt), .act_cnt(act_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [3:0] c, input logic [1:0] b,
                        input logic [12:0] a, input logic rf);
      {cs_n, ras_n, cas_n, we_n} = c;
      ba       = b;
      addr     = a;
      rd_first = rf;
      @(posedge clk);
      #1;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) drive(C_NOP, 2'd0, 13'h0000, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nops(1);
      rst = 1'b0;
   endtask

   task automatic do_init();
      do_reset();
      nops(10000);
      drive(C_PRE, 2'd0, 13'h0400, 1'b0);
      nops(2);
      drive(C_AREF, 2'd0, 13'h0000, 1'b0);
      nops(6);
      drive(C_AREF, 2'd0, 13'h0000, 1'b0);
      nops(6);
      drive(C_MRS, 2'd0, 13'h0033, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done: got %b want 0", init_done); end
      total++; if (cas_lat !== 2'd3) begin bad++; $display("FAIL rst_cas_lat: got %0d want 3", cas_lat); end
      total++; if (err_sticky !== 9'h000) begin bad++; $display("FAIL rst_sticky: got %h want 000", err_sticky); end
      total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse: got %b want 0", err_pulse); end
      total++; if (aref_cnt !== 16'd0 || act_cnt !== 16'd0) begin bad++; $display("FAIL rst_counts: got %0d/%0d want 0/0", aref_cnt, act_cnt); end
   endtask

   task automatic test_early_cmd();
      do_reset();
      nops(5000);
      drive(C_ACT, 2'd0, 13'h0000, 1'b0);
      total++; if (err_sticky !== 9'h001) begin bad++; $display("FAIL early_sticky: got %h want 001", err_sticky); end
      total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL early_pulse: got %b want 1", err_pulse); end
      total++; if (act_cnt !== 16'd1) begin bad++; $display("FAIL early_act_cnt: got %0d want 1", act_cnt); end
      nops(1);
      total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL early_pulse_drop: got %b want 0", err_pulse); end
      total++; if (init_done !== 1'b0) begin bad++; $display("FAIL early_init_done: got %b want 0", init_done); end
   endtask

   task automatic test_init();
      do_reset();
      nops(10000);
      drive(C_PRE, 2'd0, 13'h0400, 1'b0);
      nops(2);
      drive(C_AREF, 2'd0, 13'h0000, 1'b0);
      nops(6);
      drive(C_AREF, 2'd0, 13'h0000, 1'b0);
      nops(6);
      total++; if (init_done !== 1'b0) begin bad++; $display("FAIL init_before_mrs: got %b want 0", init_done); end
      drive(C_MRS, 2'd0, 13'h0033, 1'b0);
      total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_done: got %b want 1", init_done); end
      total++; if (cas_lat !== 2'd3) begin bad++; $display("FAIL init_cas_lat: got %0d want 3", cas_lat); end
      total++; if (err_sticky !== 9'h000) begin bad++; $display("FAIL init_sticky: got %h want 000", err_sticky); end
      total++; if (aref_cnt !== 16'd2) begin bad++; $display("FAIL init_aref_cnt: got %0d want 2", aref_cnt); end
   endtask

   // Continues in RUN straight after test_init.
   task automatic test_mode();
      nops(1);
      drive(C_MRS, 2'd0, 13'h000F, 1'b0);
      total++; if (err_sticky !== 9'h040) begin bad++; $display("FAIL mode_full_page: got %h want 040", err_sticky); end
      total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL mode_pulse: got %b want 1", err_pulse); end
      total++; if (cas_lat !== 2'd3) begin bad++; $display("FAIL mode_cas_kept: got %0d want 3", cas_lat); end
      nops(1);
      drive(C_MRS, 2'd0, 13'h0023, 1'b0);
      total++; if (cas_lat !== 2'd2) begin bad++; $display("FAIL mode_cas2: got %0d want 2", cas_lat); end
      nops(1);
      drive(C_MRS, 2'd0, 13'h0043, 1'b0);
      total++; if (cas_lat !== 2'd2) begin bad++; $display("FAIL mode_cl100_kept: got %0d want 2", cas_lat); end
      nops(1);
      drive(C_MRS, 2'd0, 13'h003F, 1'b0);
      total++; if (cas_lat !== 2'd2) begin bad++; $display("FAIL mode_interleave_kept: got %0d want 2", cas_lat); end
      total++; if (err_sticky !== 9'h040) begin bad++; $display("FAIL mode_sticky: got %h want 040", err_sticky); end
   endtask

   task automatic test_trcd_row();
      nops(1);
      drive(C_ACT, 2'd1, 13'h0000, 1'b0);
      nops(1);
      drive(C_RD, 2'd1, 13'h0000, 1'b0);
      total++; if (err_sticky !== 9'h044) begin bad++; $display("FAIL trcd_short: got %h want 044", err_sticky); end
      total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL trcd_pulse: got %b want 1", err_pulse); end
      drive(C_NOP, 2'd0, 13'h0000, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 1'b1);
      drive(C_PRE, 2'd1, 13'h0000, 1'b0);
      nops(2);
      drive(C_ACT, 2'd1, 13'h0000, 1'b0);
      nops(2);
      drive(C_RD, 2'd1, 13'h0000, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 1'b1);
      total++; if (err_sticky !== 9'h044 || err_pulse !== 1'b0) begin bad++; $display("FAIL trcd_exact: got %h/%b want 044/0", err_sticky, err_pulse); end
      drive(C_RD, 2'd2, 13'h0000, 1'b0);
      total++; if (err_sticky !== 9'h064) begin bad++; $display("FAIL row_idle_read: got %h want 064", err_sticky); end
      drive(C_NOP, 2'd0, 13'h0000, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 1'b1);
   endtask

   task automatic test_cas();
      drive(C_ACT, 2'd0, 13'h0000, 1'b0);
      nops(2);
      drive(C_RD, 2'd0, 13'h0000, 1'b0);
      drive(C_RD, 2'd0, 13'h0000, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 1'b1);
      drive(C_NOP, 2'd0, 13'h0000, 1'b1);
      drive(C_NOP, 2'd0, 13'h0000, 1'b0);
      total++; if (err_sticky !== 9'h064 || err_pulse !== 1'b0) begin bad++; $display("FAIL cas_back_to_back: got %h/%b want 064/0", err_sticky, err_pulse); end
      drive(C_RD, 2'd0, 13'h0000, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 1'b0);
      drive(C_NOP, 2'd0, 13'h0000, 1'b0);
      total++; if (err_sticky !== 9'h0E4) begin bad++; $display("FAIL cas_missed: got %h want 0e4", err_sticky); end
      total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL cas_pulse: got %b want 1", err_pulse); end
      drive(C_NOP, 2'd0, 13'h0000, 1'b1);
      total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL cas_single_pulse: got %b want 0", err_pulse); end
      total++; if (act_cnt !== 16'd3) begin bad++; $display("FAIL run_act_cnt: got %0d want 3", act_cnt); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      drive(C_ACT, 2'd3, 13'h0000, 1'b0);
      rst = 1'b0;
      total++; if (init_done !== 1'b0 || cas_lat !== 2'd3) begin bad++; $display("FAIL mid_rst_state: got %b/%0d want 0/3", init_done, cas_lat); end
      total++; if (err_sticky !== 9'h000 || err_pulse !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %h/%b want 000/0", err_sticky, err_pulse); end
      total++; if (aref_cnt !== 16'd0 || act_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_counts: got %0d/%0d want 0/0", aref_cnt, act_cnt); end
   endtask

   task automatic test_timing();
      do_init();
      drive(C_PRE, 2'd0, 13'h0400, 1'b0);
      total++; if (err_sticky !== 9'h010) begin bad++; $display("FAIL tmrd_short: got %h want 010", err_sticky); end
      nops(1);
      drive(C_ACT, 2'd0, 13'h0000, 1'b0);
      total++; if (err_sticky !== 9'h012) begin bad++; $display("FAIL trp_short: got %h want 012", err_sticky); end
      nops(2);
      drive(C_PRE, 2'd0, 13'h0000, 1'b0);
      nops(2);
      drive(C_AREF, 2'd0, 13'h0000, 1'b0);
      total++; if (err_sticky !== 9'h012 || aref_cnt !== 16'd3) begin bad++; $display("FAIL aref_legal: got %h/%0d want 012/3", err_sticky, aref_cnt); end
      nops(5);
      drive(C_ACT, 2'd0, 13'h0000, 1'b0);
      total++; if (err_sticky !== 9'h01A) begin bad++; $display("FAIL trfc_short: got %h want 01a", err_sticky); end
      nops(2);
      drive(C_AREF, 2'd0, 13'h0000, 1'b0);
      total++; if (err_sticky !== 9'h03A) begin bad++; $display("FAIL aref_open_bank: got %h want 03a", err_sticky); end
   endtask

   task automatic test_refi();
      do_init();
      nops(779);
      total++; if (err_sticky !== 9'h000) begin bad++; $display("FAIL refi_early: got %h want 000", err_sticky); end
      nops(1);
      total++; if (err_sticky !== REFI_BIT) begin bad++; $display("FAIL refi_expired: got %h want %h", err_sticky, REFI_BIT); end
   endtask

   initial begin
      test_reset();
      test_early_cmd();
      test_init();
      test_mode();
      test_trcd_row();
      test_cas();
      test_reset_mid();
      test_timing();
      test_refi();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
